// File: rtl/vram_fetch_pkg.sv
// Shared definitions for the VRAM fetch controller: graphics mode encodings,
// fetch/CPU arbitration FSM states and the fetch period for each mode.
package vram_fetch_pkg;

  typedef enum logic [2:0] {
    GFX_8P_2BIT      = 3'd0,
    GFX_4P_2BIT      = 3'd1,
    GFX_4P_1BIT      = 3'd2,
    GFX_2P_1BIT      = 3'd3,
    GFX_2P_1BIT_HALF = 3'd4
  } gfx_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_V_ADDR,
    ST_V_DATA,
    ST_C_ADDR,
    ST_C_DATA
  } fetch_state_e;

  localparam int unsigned PERIOD_WIDE   = 32;
  localparam int unsigned PERIOD_NARROW = 16;
  localparam int unsigned PERIOD_HALF   = 8;

  // Reserved encodings (5-7) never fetch and never restrict CPU access.
  function automatic logic mode_fetches(input logic [2:0] mode);
    return (mode <= GFX_2P_1BIT_HALF);
  endfunction

  // Periods are powers of two, so the phase is graph_pixel masked by period-1.
  function automatic logic [4:0] phase_mask(input logic [2:0] mode);
    case (mode)
      GFX_8P_2BIT, GFX_4P_1BIT:      return 5'(PERIOD_WIDE - 1);
      GFX_4P_2BIT, GFX_2P_1BIT:      return 5'(PERIOD_NARROW - 1);
      GFX_2P_1BIT_HALF:              return 5'(PERIOD_HALF - 1);
      default:                       return '0;
    endcase
  endfunction

endpackage

// File: rtl/vram_fetch_ctrl.sv
// Single-port VRAM arbiter: periodic video byte fetches with CPU accesses slotted
// between them. Optional VRAM_LINE_REPEAT_EN repeats each row rep_count+1 lines.
module vram_fetch_ctrl
  import vram_fetch_pkg::*;
#(
  parameter int unsigned VRAM_AW = 13
) (
  input  logic               pixel_clock,
  input  logic               reset,
  input  logic               frame_start,
  input  logic               line_start,
  input  logic               h_active,
  input  logic [2:0]         gfx_mode,
  input  logic [VRAM_AW-1:0] base_addr,
`ifdef VRAM_LINE_REPEAT_EN
  input  logic [1:0]         rep_count,
`endif
  output logic [8:0]         graph_pixel,
  output logic [7:0]         pixel_code,
  output logic [VRAM_AW-1:0] vram_addr,
  output logic               vram_we,
  output logic [7:0]         vram_wdata,
  input  logic [7:0]         vram_rdata,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [VRAM_AW-1:0] cpu_addr,
  input  logic [7:0]         cpu_wdata,
  output logic               cpu_ack,
  output logic [7:0]         cpu_rdata
);

  localparam logic [VRAM_AW-1:0] ADDR_ONE = VRAM_AW'(1);

  fetch_state_e       state;
  logic [VRAM_AW-1:0] row_addr;
  logic [VRAM_AW-1:0] fetch_addr;
  logic [VRAM_AW-1:0] fetch_cnt;
  logic [VRAM_AW-1:0] next_row;
  logic [7:0]         cpu_rdata_q;
  logic               cpu_write_q;
  logic [4:0]         mask;
  logic [4:0]         phase;
  logic               fetching_mode;
  logic               fetch_due;
  logic               cpu_blocked;
  logic               cpu_start;
  logic               fetch_done;

`ifdef VRAM_LINE_REPEAT_EN
  logic [1:0]         line_cnt;
`endif

  always_comb begin
    mask          = phase_mask(gfx_mode);
    fetching_mode = mode_fetches(gfx_mode);
    phase         = graph_pixel[4:0] & mask;
    fetch_due     = h_active && fetching_mode && (phase == 5'd1);
    // A CPU access takes three cycles from IDLE; starting at phase P-1 or 0
    // would leave the FSM busy at the next phase-1 fetch slot.
    cpu_blocked   = h_active && fetching_mode && ((phase == mask) || (phase == 5'd0));
    cpu_start     = cpu_req && !fetch_due && !cpu_blocked;
    fetch_done    = (state == ST_V_DATA);
    next_row      = row_addr + fetch_cnt;
  end

  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      graph_pixel <= '0;
    end else if (line_start) begin
      graph_pixel <= '0;
    end else if (h_active && (graph_pixel != '1)) begin
      graph_pixel <= graph_pixel + 9'd1;
    end
  end

  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      row_addr   <= '0;
      fetch_addr <= '0;
      fetch_cnt  <= '0;
`ifdef VRAM_LINE_REPEAT_EN
      line_cnt   <= '0;
`endif
    end else if (frame_start) begin
      row_addr   <= base_addr;
      fetch_addr <= base_addr;
      fetch_cnt  <= '0;
`ifdef VRAM_LINE_REPEAT_EN
      line_cnt   <= '0;
`endif
    end else if (line_start) begin
      fetch_cnt <= '0;
`ifdef VRAM_LINE_REPEAT_EN
      if (line_cnt == rep_count) begin
        row_addr   <= next_row;
        fetch_addr <= next_row;
        line_cnt   <= '0;
      end else begin
        fetch_addr <= row_addr;
        line_cnt   <= line_cnt + 2'd1;
      end
`else
      row_addr   <= next_row;
      fetch_addr <= next_row;
`endif
    end else if (fetch_done) begin
      fetch_addr <= fetch_addr + ADDR_ONE;
      fetch_cnt  <= fetch_cnt + ADDR_ONE;
    end
  end

  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      vram_addr   <= '0;
      vram_we     <= 1'b0;
      vram_wdata  <= '0;
      pixel_code  <= '0;
      cpu_rdata_q <= '0;
      cpu_write_q <= 1'b0;
      cpu_ack     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fetch_due) begin
            vram_addr <= fetch_addr;
            vram_we   <= 1'b0;
            state     <= ST_V_ADDR;
          end else if (cpu_start) begin
            vram_addr   <= cpu_addr;
            vram_we     <= cpu_we;
            vram_wdata  <= cpu_wdata;
            cpu_write_q <= cpu_we;
            state       <= ST_C_ADDR;
          end
        end
        ST_V_ADDR: state <= ST_V_DATA;
        ST_V_DATA: begin
          pixel_code <= vram_rdata;
          state      <= ST_IDLE;
        end
        ST_C_ADDR: begin
          vram_we <= 1'b0;
          cpu_ack <= 1'b1;
          state   <= ST_C_DATA;
        end
        ST_C_DATA: begin
          if (!cpu_write_q) begin
            cpu_rdata_q <= vram_rdata;
          end
          vram_we <= 1'b0;
          cpu_ack <= 1'b0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The ack cycle is the cycle RAM data arrives, so read data bypasses the
  // holding register during that cycle to be valid together with cpu_ack.
  assign cpu_rdata = ((state == ST_C_DATA) && !cpu_write_q) ? vram_rdata : cpu_rdata_q;

endmodule

// File: tb/tb_vram_fetch_ctrl.sv
// Self-checking bench for vram_fetch_ctrl: behavioural VRAM, video fetch
// scoreboard and a CPU request agent.
module tb_vram_fetch_ctrl;

  localparam int unsigned AW = 13;

  logic          pixel_clock = 1'b0;
  logic          reset;
  logic          frame_start;
  logic          line_start;
  logic          h_active;
  logic [2:0]    gfx_mode;
  logic [AW-1:0] base_addr;
`ifdef VRAM_LINE_REPEAT_EN
  logic [1:0]    rep_count;
`endif
  logic [8:0]    graph_pixel;
  logic [7:0]    pixel_code;
  logic [AW-1:0] vram_addr;
  logic          vram_we;
  logic [7:0]    vram_wdata;
  logic [7:0]    vram_rdata;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_wdata;
  logic          cpu_ack;
  logic [7:0]    cpu_rdata;

  always #5 pixel_clock = ~pixel_clock;

  vram_fetch_ctrl #(.VRAM_AW(AW)) dut (
    .pixel_clock (pixel_clock),
    .reset       (reset),
    .frame_start (frame_start),
    .line_start  (line_start),
    .h_active    (h_active),
    .gfx_mode    (gfx_mode),
    .base_addr   (base_addr),
`ifdef VRAM_LINE_REPEAT_EN
    .rep_count   (rep_count),
`endif
    .graph_pixel (graph_pixel),
    .pixel_code  (pixel_code),
    .vram_addr   (vram_addr),
    .vram_we     (vram_we),
    .vram_wdata  (vram_wdata),
    .vram_rdata  (vram_rdata),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_ack     (cpu_ack),
    .cpu_rdata   (cpu_rdata)
  );

  function automatic logic [7:0] pat(input logic [AW-1:0] a);
    return a[7:0] ^ {a[12:8], 3'b011};
  endfunction

  logic [7:0] vram [0:(1<<AW)-1];
  initial for (int i = 0; i < (1 << AW); i++) vram[i] = pat(AW'(i));
  always @(posedge pixel_clock) begin
    if (vram_we) vram[vram_addr] <= vram_wdata;
    vram_rdata <= vram[vram_addr];
  end

  typedef struct {
    int unsigned   addr_cyc;
    int unsigned   code_cyc;
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } vfetch_t;

  vfetch_t     vq[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned cyc      = 0;
  logic [7:0]  last_code  = '0;
  logic [7:0]  last_rdata = '0;
  bit          cpu_pending = 0;
  bit          cpu_exact   = 0;
  bit          phase_chk   = 0;
  int unsigned cpu_req_cyc, cpu_bound;
  logic [7:0]  cpu_exp;
  int unsigned line_c0 = 0, line_n = 0, cur_p = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic cpu_issue(input logic we, input logic [AW-1:0] a, input logic [7:0] d,
                           input logic [7:0] exp, input int unsigned bound, input bit exact);
    cpu_req     = 1'b1;
    cpu_we      = we;
    cpu_addr    = a;
    cpu_wdata   = d;
    cpu_exp     = exp;
    cpu_pending = 1;
    cpu_req_cyc = cyc;
    cpu_bound   = bound;
    cpu_exact   = exact;
  endtask

  task automatic monitor();
    int unsigned lat, gp, ph;
    if (vq.size() > 0 && cyc == vq[0].addr_cyc) begin
      check_eq("video_addr", vram_addr, vq[0].addr);
      check_eq("video_we", vram_we, 0);
    end
    if (vq.size() > 0 && cyc == vq[0].code_cyc) begin
      last_code = vq[0].data;
      void'(vq.pop_front());
      check_eq("pixel_code", pixel_code, last_code);
    end else begin
      check_eq("pixel_code_hold", pixel_code, last_code);
    end
    if (cpu_ack) begin
      if (!cpu_pending) begin
        check_eq("cpu_ack_spurious", cpu_ack, 0);
      end else begin
        lat = cyc - cpu_req_cyc;
        if (cpu_exact) check_eq("cpu_ack_latency", lat, 2);
        else           check_eq("cpu_ack_late", lat > cpu_bound, 0);
        check_eq("cpu_rdata", cpu_rdata, cpu_exp);
        last_rdata = cpu_exp;
        if (phase_chk && cyc - line_c0 <= line_n) begin
          gp = cyc - line_c0;
          ph = gp % cur_p;
          check_eq("cpu_ack_phase", (ph >= 1 && ph <= 3), 0);
        end
        cpu_req     = 1'b0;
        cpu_pending = 0;
      end
    end else if (cpu_pending && (cyc - cpu_req_cyc) > cpu_bound) begin
      check_eq("cpu_ack_timeout", cpu_ack, 1);
      cpu_req     = 1'b0;
      cpu_pending = 0;
    end
  endtask

  task automatic step();
    @(posedge pixel_clock);
    #1;
    cyc++;
    monitor();
  endtask

  task automatic run_line(input logic [2:0] mode, input int unsigned n, input bit fs,
                          input logic [AW-1:0] first, input bit cpu_traffic);
    int unsigned p;
    int unsigned nf = 0;
    int unsigned nreq = 0;
    logic [AW-1:0] a;
    p = (mode == 3'd0 || mode == 3'd2) ? 32 :
        (mode == 3'd1 || mode == 3'd3) ? 16 :
        (mode == 3'd4) ? 8 : 0;
    gfx_mode    = mode;
    line_start  = 1'b1;
    frame_start = fs;
    step();
    line_start  = 1'b0;
    frame_start = 1'b0;
    check_eq("gp_line_start", graph_pixel, 0);
    line_c0 = cyc;
    line_n  = n;
    cur_p   = p;
    if (p != 0) begin
      for (int unsigned k = 1; k < n; k += p) begin
        vfetch_t e;
        e.addr_cyc = cyc + k + 1;
        e.code_cyc = cyc + k + 3;
        e.addr     = first + AW'(nf);
        e.data     = pat(e.addr);
        vq.push_back(e);
        nf++;
      end
    end
    h_active  = 1'b1;
    phase_chk = cpu_traffic;
    for (int unsigned k = 1; k <= n; k++) begin
      step();
      if (k == 1 || k == n || k % 64 == 0)
        check_eq("graph_pixel", graph_pixel, (k > 511) ? 511 : k);
      if (cpu_traffic && !cpu_pending && k + 24 < n && $urandom_range(0, 2) == 0) begin
        a = (nreq == 0) ? AW'(13'h0055) : AW'(13'h0055) + AW'($urandom_range(0, 15));
        cpu_issue(1'b0, a, 8'h00, pat(a), 8, 0);
        nreq++;
      end
    end
    h_active  = 1'b0;
    phase_chk = 0;
    for (int i = 0; i < 6; i++) step();
    check_eq("fetch_queue_empty", vq.size(), 0);
    vq.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int unsigned we_cycles;
    reset = 1'b1; frame_start = 1'b0; line_start = 1'b0; h_active = 1'b0;
    gfx_mode = 3'd0; base_addr = '0;
`ifdef VRAM_LINE_REPEAT_EN
    rep_count = 2'd0;
`endif
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    repeat (3) step();
    check_eq("rst_graph_pixel", graph_pixel, 0);
    check_eq("rst_vram_addr", vram_addr, 0);
    check_eq("rst_vram_we", vram_we, 0);
    check_eq("rst_vram_wdata", vram_wdata, 0);
    check_eq("rst_cpu_ack", cpu_ack, 0);
    check_eq("rst_cpu_rdata", cpu_rdata, 0);
    reset = 1'b0;
    step();

    // Mode 3 from 0x100, then row advance, then frame_start reloading a new base
    base_addr = 13'h0100;
    run_line(3'd3, 256, 1, 13'h0100, 0);
    run_line(3'd1, 256, 0, 13'h0110, 0);
    base_addr = 13'h0200;
    run_line(3'd1, 64, 1, 13'h0200, 0);

    // Address wrap at the top of VRAM, then a line with CPU reads interleaved
    base_addr = 13'h1FFE;
    run_line(3'd4, 30, 1, 13'h1FFE, 0);
    run_line(3'd4, 256, 0, 13'h0002, 1);

    // Blanking CPU write and read-back
    step();
    we_cycles = 0;
    cpu_issue(1'b1, 13'h1234, 8'h0A, last_rdata, 4, 1);
    for (int i = 0; i < 6; i++) begin
      step();
      if (vram_we) begin
        we_cycles++;
        check_eq("wr_addr", vram_addr, 13'h1234);
        check_eq("wr_data", vram_wdata, 8'h0A);
      end
    end
    check_eq("wr_pulse_cycles", we_cycles, 1);
    cpu_issue(1'b0, 13'h1234, 8'h00, 8'h0A, 4, 1);
    repeat (5) step();

    // Wide-period modes (row advanced by 32 fetches of the previous line)
    run_line(3'd0, 70, 0, 13'h0022, 0);
    run_line(3'd2, 40, 0, 13'h0025, 0);
    // Reserved mode: no fetches, pixel index saturates
    run_line(3'd5, 520, 0, 13'h0000, 0);

    // Reset while a CPU read sits in its address cycle: no ack may follow
    cpu_issue(1'b0, 13'h0300, 8'h00, pat(13'h0300), 8, 0);
    step();
    reset = 1'b1;
    cpu_req = 1'b0;
    cpu_pending = 0;
    last_code = '0;
    last_rdata = '0;
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("ack_after_reset", cpu_ack, 0);
    end
    check_eq("rdata_after_reset", cpu_rdata, 0);
    cpu_issue(1'b0, 13'h0300, 8'h00, pat(13'h0300), 4, 1);
    repeat (5) step();

`ifdef VRAM_LINE_REPEAT_EN
    rep_count = 2'd1;
    base_addr = 13'h0300;
    run_line(3'd3, 40, 1, 13'h0300, 0);
    run_line(3'd3, 40, 0, 13'h0300, 0);
    run_line(3'd3, 40, 0, 13'h0303, 0);
    run_line(3'd3, 40, 0, 13'h0303, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
